// File: rtl/sram_ctrl.sv
// sram_ctrl: turns single-cycle CPU requests into async 16-bit SRAM read/write cycles (setup, strobe, hold).
// Latency: request edge N -> done (and read data) valid between edges N+1+WAIT_CYCLES and N+2+WAIT_CYCLES.
// Backpressure: busy is high outside IDLE; req is only sampled in IDLE and is never queued.
module sram_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req,
  input  logic        wr,
  input  logic [19:0] addr,
  input  logic [15:0] wdata,
  input  logic [1:0]  be,
  output logic [15:0] rdata,
  output logic        done,
  output logic        busy,
  output logic [19:0] A,
  inout  wire  [15:0] I_O,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // The strobe counter is 4 bits wide, so the wait count must fit in 1..15.
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("sram_ctrl: WAIT_CYCLES must be in 1..15");
  end

  logic [1:0]  state;
  logic [3:0]  wait_cnt;
  logic        wr_q;
  logic [19:0] addr_q;
  logic [15:0] wdata_q;
  logic [1:0]  be_q;
  logic        io_drive;

  // Request latches: captured only on an accepted request so the pins never follow live CPU inputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_q    <= 1'b0;
      addr_q  <= 20'h0;
      wdata_q <= 16'h0;
      be_q    <= 2'b00;
    end else if (state == ST_IDLE && req) begin
      wr_q    <= wr;
      addr_q  <= addr;
      wdata_q <= wdata;
      be_q    <= be;
    end
  end

  // Cycle sequencer: SETUP for one cycle, ACCESS for WAIT_CYCLES cycles, HOLD for one cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) state <= ST_SETUP;
        end
        ST_SETUP: begin
          wait_cnt <= 4'(WAIT_CYCLES - 1);
          state    <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (wait_cnt == 4'h0) state <= ST_HOLD;
          else                  wait_cnt <= wait_cnt - 4'h1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read capture on the last ACCESS edge; disabled byte lanes read back as zero.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rdata <= 16'h0;
    end else if (state == ST_ACCESS && wait_cnt == 4'h0 && !wr_q) begin
      rdata[15:8] <= be_q[1] ? I_O[15:8] : 8'h00;
      rdata[7:0]  <= be_q[0] ? I_O[7:0]  : 8'h00;
    end
  end

  // Pin decode from state and latches only, so no CPU-input glitch reaches the SRAM.
  always_comb begin
    A        = 20'h0;
    CE       = 1'b1;
    UB       = 1'b1;
    LB       = 1'b1;
    OE       = 1'b1;
    WE       = 1'b1;
    io_drive = 1'b0;
    busy     = (state != ST_IDLE);
    done     = (state == ST_HOLD);
    if (state != ST_IDLE) begin
      A        = addr_q;
      CE       = 1'b0;
      UB       = ~be_q[1];
      LB       = ~be_q[0];
      // Data is driven through SETUP, ACCESS and HOLD of a write; OE never falls on a write.
      io_drive = wr_q;
      if (state == ST_ACCESS) begin
        OE = wr_q;
        WE = ~wr_q;
      end
    end
  end

  assign I_O = io_drive ? wdata_q : 16'hzzzz;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: two controllers (WAIT_CYCLES 1 and 4) each attached to a small async SRAM model.
// A transaction-level reference tracks phase-by-cycle-count and a reference memory; every cycle is compared.
// Directed scenarios add literal expectations for latency, strobe widths, byte lanes and reset abort.
module tb_sram_ctrl;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  logic        req [2];
  logic        wr [2];
  logic [19:0] addr [2];
  logic [15:0] wdata [2];
  logic [1:0]  be [2];
  logic [15:0] rdata [2];
  logic        done [2];
  logic        busy [2];
  logic [19:0] A [2];
  logic        ce [2];
  logic        ub [2];
  logic        lb [2];
  logic        oe [2];
  logic        we [2];
  wire  [15:0] io0;
  wire  [15:0] io1;

  sram_ctrl #(.WAIT_CYCLES(1)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .req(req[0]), .wr(wr[0]), .addr(addr[0]), .wdata(wdata[0]),
    .be(be[0]), .rdata(rdata[0]), .done(done[0]), .busy(busy[0]), .A(A[0]), .I_O(io0),
    .CE(ce[0]), .UB(ub[0]), .LB(lb[0]), .OE(oe[0]), .WE(we[0]));

  sram_ctrl #(.WAIT_CYCLES(4)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .req(req[1]), .wr(wr[1]), .addr(addr[1]), .wdata(wdata[1]),
    .be(be[1]), .rdata(rdata[1]), .done(done[1]), .busy(busy[1]), .A(A[1]), .I_O(io1),
    .CE(ce[1]), .UB(ub[1]), .LB(lb[1]), .OE(oe[1]), .WE(we[1]));

  // Async SRAM models: drive the whole word while CE and OE are low, write enabled lanes while WE is low.
  logic [15:0] smem0 [256];
  logic [15:0] smem1 [256];
  assign io0 = (!ce[0] && !oe[0]) ? smem0[A[0][7:0]] : 16'hzzzz;
  assign io1 = (!ce[1] && !oe[1]) ? smem1[A[1][7:0]] : 16'hzzzz;

  always @(negedge Clk) begin
    if (!ce[0] && !we[0]) begin
      if (!ub[0]) smem0[A[0][7:0]][15:8] = io0[15:8];
      if (!lb[0]) smem0[A[0][7:0]][7:0]  = io0[7:0];
    end
    if (!ce[1] && !we[1]) begin
      if (!ub[1]) smem1[A[1][7:0]][15:8] = io1[15:8];
      if (!lb[1]) smem1[A[1][7:0]][7:0]  = io1[7:0];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transaction occupies cycles 0 (setup), 1..W (strobe), W+1 (hold) after its request edge.
  int          wc [2] = '{1, 4};
  int          ph [2] = '{-1, -1};
  int          start_cyc [2] = '{0, 0};
  int          cyc = 0;
  logic        m_wr [2];
  logic [19:0] m_addr [2];
  logic [15:0] m_wdata [2];
  logic [1:0]  m_be [2];
  logic [15:0] exp_rdata [2] = '{16'h0, 16'h0};
  logic [15:0] rmem [2][256];
  logic        run_chk = 1'b0;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int d = 0; d < 2; d++) begin
        ph[d]        = -1;
        exp_rdata[d] = 16'h0;
      end
    end else begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (ph[d] < 0) begin
          if (req[d]) begin
            m_wr[d] = wr[d]; m_addr[d] = addr[d]; m_wdata[d] = wdata[d]; m_be[d] = be[d];
            ph[d] = 0;
            start_cyc[d] = cyc;
          end
        end else if (ph[d] == wc[d] + 1) begin
          ph[d] = -1;
        end else begin
          ph[d]++;
          if (ph[d] == wc[d] + 1) begin
            if (m_wr[d]) begin
              if (m_be[d][1]) rmem[d][m_addr[d][7:0]][15:8] = m_wdata[d][15:8];
              if (m_be[d][0]) rmem[d][m_addr[d][7:0]][7:0]  = m_wdata[d][7:0];
            end else begin
              exp_rdata[d][15:8] = m_be[d][1] ? rmem[d][m_addr[d][7:0]][15:8] : 8'h00;
              exp_rdata[d][7:0]  = m_be[d][0] ? rmem[d][m_addr[d][7:0]][7:0]  : 8'h00;
            end
          end
        end
      end
    end
  end

  function automatic logic [26:0] exp_pins(input int d);
    logic on;
    logic acc;
    on  = (ph[d] >= 0);
    acc = (ph[d] >= 1) && (ph[d] <= wc[d]);
    return {on ? m_addr[d] : 20'h0, !on, on ? ~m_be[d][1] : 1'b1, on ? ~m_be[d][0] : 1'b1,
            !(acc && !m_wr[d]), !(acc && m_wr[d]), on, (ph[d] == wc[d] + 1)};
  endfunction

  function automatic logic [26:0] act_pins(input int d);
    return {A[d], ce[d], ub[d], lb[d], oe[d], we[d], busy[d], done[d]};
  endfunction

  function automatic logic [15:0] io_val(input int d);
    return (d == 0) ? io0 : io1;
  endfunction

  // Per-cycle comparison against the reference model.
  always @(negedge Clk) begin
    if (run_chk) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("pins d%0d", d), 32'(act_pins(d)), 32'(exp_pins(d)));
        chk($sformatf("rdata d%0d", d), 32'(rdata[d]), 32'(exp_rdata[d]));
        if (ph[d] >= 0 && m_wr[d])
          chk($sformatf("wdata on bus d%0d", d), 32'(io_val(d)), 32'(m_wdata[d]));
      end
    end
  end

  // Per-transaction observations gathered by run().
  int          r_we, r_oe, r_busy, r_done, r_dcyc, r_lane;
  logic [15:0] r_dat;

  task automatic run(input int d, input logic w, input logic [19:0] ad, input logic [15:0] wd,
                     input logic [1:0] b);
    int n;
    @(negedge Clk);
    req[d] = 1'b1; wr[d] = w; addr[d] = ad; wdata[d] = wd; be[d] = b;
    @(negedge Clk);
    // Inputs are scrambled after the request edge; the cycle must use the latched values.
    req[d] = 1'b0; wr[d] = ~w; addr[d] = 20'hFFFFF; wdata[d] = 16'h0; be[d] = ~b;
    r_we = 0; r_oe = 0; r_busy = 0; r_done = 0; r_dcyc = 0; r_lane = 0; r_dat = 16'h0;
    n = 0;
    while (busy[d] && n < 40) begin
      r_busy++;
      if (!we[d]) r_we++;
      if (!oe[d]) r_oe++;
      if (!ub[d] || !lb[d]) r_lane++;
      if (done[d]) begin
        r_done++;
        r_dcyc = cyc - start_cyc[d];
        r_dat  = rdata[d];
      end
      n++;
      @(negedge Clk);
    end
    if (n >= 40) chk($sformatf("timeout waiting for busy to fall d%0d", d), 32'(n), 32'(0));
  endtask

  int dn_cnt;
  int dn_first;
  int dn_last;

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; addr[d] = 20'h0; wdata[d] = 16'h0; be[d] = 2'b00;
      for (int i = 0; i < 256; i++) rmem[d][i] = 16'h0;
    end
    for (int i = 0; i < 256; i++) begin
      smem0[i] = 16'h0;
      smem1[i] = 16'h0;
    end
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("reset pins d0", 32'(act_pins(0)), 32'({20'h0, 7'b1111100}));
    chk("reset rdata d0", 32'(rdata[0]), 32'(16'h0));
    run_chk = 1'b1;

    // Basic write then read, W=1.
    run(0, 1'b1, 20'h00010, 16'hBEEF, 2'b11);
    chk("write WE low cycles", r_we, 1);
    chk("write OE low cycles", r_oe, 0);
    chk("write done latency", r_dcyc, 2);
    chk("write busy cycles", r_busy, 3);
    chk("write done count", r_done, 1);
    run(0, 1'b0, 20'h00010, 16'h0000, 2'b11);
    chk("read back BEEF", 32'(r_dat), 32'(16'hBEEF));
    chk("read OE low cycles", r_oe, 1);

    // Byte lanes.
    run(0, 1'b1, 20'h00011, 16'h1234, 2'b11);
    run(0, 1'b1, 20'h00011, 16'hAB00, 2'b10);
    chk("upper-lane write result", 32'(smem0[8'h11]), 32'(16'hAB34));
    run(0, 1'b0, 20'h00011, 16'h0000, 2'b01);
    chk("lower-lane read", 32'(r_dat), 32'(16'h0034));

    // be=00 read of 0xFFFF.
    run(0, 1'b1, 20'h00020, 16'hFFFF, 2'b11);
    run(0, 1'b0, 20'h00020, 16'h0000, 2'b00);
    chk("be00 read data", 32'(r_dat), 32'(16'h0000));
    chk("be00 lane strobes low", r_lane, 0);
    chk("be00 done count", r_done, 1);

    // Wait states, W=4.
    run(1, 1'b1, 20'h00030, 16'h5A5A, 2'b11);
    chk("W4 write WE low cycles", r_we, 4);
    run(1, 1'b0, 20'h00030, 16'h0000, 2'b11);
    chk("W4 read OE low cycles", r_oe, 4);
    chk("W4 read done latency", r_dcyc, 5);
    chk("W4 read busy cycles", r_busy, 6);
    chk("W4 read data", 32'(r_dat), 32'(16'h5A5A));

    // req held high across two transaction slots on W=1.
    @(negedge Clk);
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 20'h00010; be[0] = 2'b11;
    dn_cnt = 0; dn_first = 0; dn_last = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) req[0] = 1'b0;
      @(negedge Clk);
      if (done[0]) begin
        if (dn_cnt == 0) dn_first = cyc;
        dn_last = cyc;
        dn_cnt++;
      end
    end
    chk("held req transaction count", dn_cnt, 2);
    chk("held req spacing", dn_last - dn_first, 4);

    // Request pulsed only during ACCESS on W=4 is ignored.
    @(negedge Clk);
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 20'h00030; be[1] = 2'b11;
    @(negedge Clk);
    req[1] = 1'b0;
    @(negedge Clk);
    req[1] = 1'b1; addr[1] = 20'h00031;
    @(negedge Clk);
    req[1] = 1'b0;
    dn_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (done[1]) dn_cnt++;
      @(negedge Clk);
    end
    chk("access-time request ignored", dn_cnt, 1);

    // Reset during a W=4 write.
    @(negedge Clk);
    req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 20'h00040; wdata[1] = 16'hC3C3; be[1] = 2'b11;
    @(negedge Clk);
    req[1] = 1'b0;
    @(negedge Clk);
    chk("mid-write WE low before reset", 32'(we[1]), 32'(0));
    #2 Reset = 1'b1;
    #1;
    chk("reset abort pins d1", 32'(act_pins(1)), 32'({20'h0, 7'b1111100}));
    chk("reset abort rdata d1", 32'(rdata[1]), 32'(16'h0));
    @(negedge Clk);
    Reset = 1'b0;
    dn_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done[1]) dn_cnt++;
      @(negedge Clk);
    end
    chk("no done after abort", dn_cnt, 0);
    run(1, 1'b1, 20'h00041, 16'h7E7E, 2'b11);
    chk("post-reset write done", r_done, 1);
    run(1, 1'b0, 20'h00041, 16'h0000, 2'b11);
    chk("post-reset read data", 32'(r_dat), 32'(16'h7E7E));

    repeat (2) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
